// File: rtl/normalizer_pkg.sv
// Shared state encoding and width helpers for the psum row normaliser.
package normalizer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SUM,
    DIV,
    OUT
  } state_t;

  function automatic int frac_w(input int w_out);
    return w_out - 1;
  endfunction

  function automatic int sum_w(input int bw_psum, input int col);
    return bw_psum + $clog2(2 * col);
  endfunction

  function automatic int div_w(input int bw_psum, input int w_out);
    return bw_psum + frac_w(w_out);
  endfunction

endpackage

// File: rtl/norm_divider.sv
// Sequential restoring unsigned divider: one quotient bit per cycle, W_OUT cycles.
module norm_divider #(
  parameter int DIV_W = 31,
  parameter int SUM_W = 20,
  parameter int W_OUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [SUM_W-1:0] divisor,
  output logic [W_OUT-1:0] quotient,
  output logic             done
);
  localparam int CW = $clog2(W_OUT + 1);

  logic [SUM_W-1:0] rem, rem_in, rem_out;
  logic [W_OUT-1:0] sh_in, sh_out;
  logic [SUM_W:0]   trial;
  logic             ge;
  logic [CW-1:0]    left;

  // Dividend bits above W_OUT are pre-loaded as the partial remainder; this is
  // exact because the caller guarantees dividend >> W_OUT < divisor.
  always_comb begin
    rem_in  = start ? SUM_W'(dividend >> W_OUT) : rem;
    sh_in   = start ? dividend[W_OUT-1:0] : quotient;
    trial   = {rem_in, sh_in[W_OUT-1]};
    ge      = (trial >= {1'b0, divisor});
    rem_out = ge ? SUM_W'(trial - {1'b0, divisor}) : trial[SUM_W-1:0];
    sh_out  = {sh_in[W_OUT-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem      <= '0;
      quotient <= '0;
      left     <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= rem_out;
        quotient <= sh_out;
        left     <= CW'(W_OUT - 1);
        done     <= (W_OUT == 1);
      end else if (left != '0) begin
        rem      <= rem_out;
        quotient <= sh_out;
        left     <= left - 1'b1;
        done     <= (left == CW'(1));
      end
    end
  end

endmodule

// File: rtl/normalizer.sv
// Normalises two captured psum rows by their joint absolute sum and streams
// the signed Q(W_OUT-1) ratios out one column per cycle.
module normalizer #(
  parameter int BW_PSUM = 16,
  parameter int COL     = 8,
  parameter int W_OUT   = BW_PSUM
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           s_valid_1,
  input  logic                           s_valid_2,
  input  logic [COL-1:0][BW_PSUM-1:0]    psum_1,
  input  logic [COL-1:0][BW_PSUM-1:0]    psum_2,
  output logic signed [W_OUT-1:0]        psum_norm_1,
  output logic signed [W_OUT-1:0]        psum_norm_2,
  output logic                           norm_valid
);
  import normalizer_pkg::*;

  localparam int FRAC  = frac_w(W_OUT);
  localparam int SUM_W = sum_w(BW_PSUM, COL);
  localparam int DIV_W = div_w(BW_PSUM, W_OUT);
  localparam int CIW   = (COL > 1) ? $clog2(COL) : 1;
  localparam int OIW   = $clog2(COL + 1);

  state_t                      state;
  logic                        have_1, have_2;
  logic [COL-1:0][BW_PSUM-1:0] buf_1, buf_2;
  logic [SUM_W-1:0]            total, sum_all;
  logic [CIW-1:0]              col, div_col;
  logic [OIW-1:0]              oidx;
  logic                        launch, start, col_done, last;
  logic [DIV_W-1:0]            dividend_1, dividend_2;
  logic [W_OUT-1:0]            quotient_1, quotient_2, fin_1, fin_2;
  logic                        done_1, done_2;
  logic [W_OUT-1:0]            res_1 [COL];
  logic [W_OUT-1:0]            res_2 [COL];

  function automatic logic [BW_PSUM-1:0] mag(input logic [BW_PSUM-1:0] p);
    return p[BW_PSUM-1] ? (~p + 1'b1) : p;
  endfunction

  // Quotient can only reach 2^FRAC when |p| == total, so its MSB flags saturation.
  function automatic logic [W_OUT-1:0] shape(input logic [W_OUT-1:0] q, input logic neg);
    logic [W_OUT-1:0] m;
    m = q[W_OUT-1] ? {1'b0, {(W_OUT-1){1'b1}}} : q;
    return neg ? (~m + 1'b1) : m;
  endfunction

  always_comb begin
    sum_all = '0;
    for (int unsigned i = 0; i < COL; i++)
      sum_all = sum_all + SUM_W'(mag(buf_1[i])) + SUM_W'(mag(buf_2[i]));
  end

  // Next column is launched on the same edge the previous one is stored.
  always_comb begin
    col_done   = done_1 & done_2;
    last       = (col == CIW'(COL - 1));
    div_col    = (col_done && !last) ? col + 1'b1 : col;
    start      = (state == DIV) && (launch || (col_done && !last));
    dividend_1 = {mag(buf_1[div_col]), {FRAC{1'b0}}};
    dividend_2 = {mag(buf_2[div_col]), {FRAC{1'b0}}};
    fin_1      = (total == '0) ? '0 : shape(quotient_1, buf_1[col][BW_PSUM-1]);
    fin_2      = (total == '0) ? '0 : shape(quotient_2, buf_2[col][BW_PSUM-1]);
  end

  norm_divider #(.DIV_W(DIV_W), .SUM_W(SUM_W), .W_OUT(W_OUT)) u_div_1 (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend_1),
    .divisor(total), .quotient(quotient_1), .done(done_1)
  );

  norm_divider #(.DIV_W(DIV_W), .SUM_W(SUM_W), .W_OUT(W_OUT)) u_div_2 (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend_2),
    .divisor(total), .quotient(quotient_2), .done(done_2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      have_1      <= 1'b0;
      have_2      <= 1'b0;
      buf_1       <= '0;
      buf_2       <= '0;
      total       <= '0;
      col         <= '0;
      oidx        <= '0;
      launch      <= 1'b0;
      norm_valid  <= 1'b0;
      psum_norm_1 <= '0;
      psum_norm_2 <= '0;
      for (int unsigned i = 0; i < COL; i++) begin
        res_1[i] <= '0;
        res_2[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (s_valid_1) begin
            buf_1  <= psum_1;
            have_1 <= 1'b1;
          end
          if (s_valid_2) begin
            buf_2  <= psum_2;
            have_2 <= 1'b1;
          end
          if ((have_1 || s_valid_1) && (have_2 || s_valid_2))
            state <= SUM;
        end
        SUM: begin
          total  <= sum_all;
          col    <= '0;
          launch <= 1'b1;
          state  <= DIV;
        end
        DIV: begin
          launch <= 1'b0;
          if (col_done) begin
            res_1[col] <= fin_1;
            res_2[col] <= fin_2;
            if (last) begin
              state       <= OUT;
              norm_valid  <= 1'b1;
              psum_norm_1 <= (col == '0) ? fin_1 : res_1[0];
              psum_norm_2 <= (col == '0) ? fin_2 : res_2[0];
              oidx        <= OIW'(1);
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        OUT: begin
          if (oidx == OIW'(COL)) begin
            norm_valid  <= 1'b0;
            psum_norm_1 <= '0;
            psum_norm_2 <= '0;
            have_1      <= 1'b0;
            have_2      <= 1'b0;
            state       <= IDLE;
          end else begin
            psum_norm_1 <= res_1[CIW'(oidx)];
            psum_norm_2 <= res_2[CIW'(oidx)];
            oidx        <= oidx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_normalizer.sv
// Directed bench for normalizer with an arithmetic reference model and literal pins.
module tb_normalizer;
  localparam int BW   = 16;
  localparam int COL  = 8;
  localparam int W    = 16;
  localparam int LAT  = 2 + COL * W;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   s_valid_1, s_valid_2;
  logic [COL-1:0][BW-1:0] psum_1, psum_2;
  logic signed [W-1:0]    psum_norm_1, psum_norm_2;
  logic                   norm_valid;

  normalizer #(.BW_PSUM(BW), .COL(COL), .W_OUT(W)) dut (
    .clk(clk), .reset(reset), .s_valid_1(s_valid_1), .s_valid_2(s_valid_2),
    .psum_1(psum_1), .psum_2(psum_2), .psum_norm_1(psum_norm_1),
    .psum_norm_2(psum_norm_2), .norm_valid(norm_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int n1; int n2; } pair_t;

  int    compared   = 0;
  int    mismatched = 0;
  pair_t exp_q[$];
  int    pa[COL];
  int    pb[COL];
  int    got1[COL];
  int    got2[COL];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int norm_one(input int p, input longint total);
    longint a, q;
    if (total == 0) return 0;
    a = (p < 0) ? -p : p;
    q = (a * 32768) / total;
    if (q > 32767) q = 32767;
    return (p < 0) ? -int'(q) : int'(q);
  endfunction

  task automatic model_push();
    longint total = 0;
    pair_t  e;
    for (int i = 0; i < COL; i++)
      total += ((pa[i] < 0) ? -pa[i] : pa[i]) + ((pb[i] < 0) ? -pb[i] : pb[i]);
    for (int k = 0; k < COL; k++) begin
      e.n1 = norm_one(pa[k], total);
      e.n2 = norm_one(pb[k], total);
      exp_q.push_back(e);
    end
  endtask

  task automatic capture(input logic v1, input logic v2);
    @(negedge clk);
    for (int i = 0; i < COL; i++) begin
      psum_1[i] = pa[i][BW-1:0];
      psum_2[i] = pb[i][BW-1:0];
    end
    s_valid_1 = v1;
    s_valid_2 = v2;
    @(posedge clk);
    #1;
    s_valid_1 = 1'b0;
    s_valid_2 = 1'b0;
  endtask

  task automatic run_burst(input bit check_lat);
    int edges = 0;
    while (norm_valid !== 1'b1 && edges < 400) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (norm_valid !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL burst_timeout: no norm_valid within %0d edges", edges);
      exp_q.delete();
      return;
    end
    if (check_lat) check("latency", edges, LAT);
    for (int k = 0; k < COL; k++) begin
      check("valid_high", int'(norm_valid), 1);
      got1[k] = psum_norm_1;
      got2[k] = psum_norm_2;
      @(posedge clk);
      #1;
    end
    check("valid_drop", int'(norm_valid), 0);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    pair_t e;
    if (reset === 1'b0) begin
      if (norm_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_valid: norm_valid high with no burst pending (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("norm_1", psum_norm_1, e.n1);
          check("norm_2", psum_norm_2, e.n2);
        end
      end else begin
        check("idle_zero_1", psum_norm_1, 0);
        check("idle_zero_2", psum_norm_2, 0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    s_valid_1 = 1'b0;
    s_valid_2 = 1'b0;
    psum_1 = '0;
    psum_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", int'(norm_valid), 0);
    check("reset_norm_1", psum_norm_1, 0);
    check("reset_norm_2", psum_norm_2, 0);
    @(negedge clk);
    reset = 1'b0;

    // Split arrival, total 136
    for (int i = 0; i < COL; i++) begin pa[i] = i + 10; pb[i] = i; end
    capture(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    model_push();
    capture(1'b0, 1'b1);
    run_burst(1'b1);
    check("A_n1_col0", got1[0], 2409);
    check("A_n1_col7", got1[7], 4096);
    check("A_n2_col0", got2[0], 0);
    check("A_n2_col7", got2[7], 1686);

    // Same data, simultaneous capture
    repeat (2) @(posedge clk);
    model_push();
    capture(1'b1, 1'b1);
    run_burst(1'b1);
    check("B_n1_col0", got1[0], 2409);
    check("B_n2_col7", got2[7], 1686);

    // Opposite signs, half each
    for (int i = 0; i < COL; i++) begin pa[i] = 0; pb[i] = 0; end
    pa[0] = -68;
    pb[0] = 68;
    model_push();
    capture(1'b1, 1'b1);
    run_burst(1'b1);
    check("C_n1_col0", got1[0], -16384);
    check("C_n2_col0", got2[0], 16384);
    check("C_n1_col1", got1[1], 0);

    // Single element: saturation
    pa[0] = 0;
    pb[0] = 0;
    pa[3] = 5;
    model_push();
    capture(1'b1, 1'b1);
    run_burst(1'b1);
    check("D_n1_col3_sat", got1[3], 32767);
    check("D_n2_col3", got2[3], 0);

    // All zero: bypass
    pa[3] = 0;
    model_push();
    capture(1'b1, 1'b1);
    run_burst(1'b1);
    check("E_n1_col3", got1[3], 0);

    // Latest capture wins; mid-DIV valid ignored
    for (int i = 0; i < COL; i++) begin pa[i] = 1000; pb[i] = 100 - 20 * i; end
    capture(1'b1, 1'b0);
    for (int i = 0; i < COL; i++) pa[i] = 3 * i - 7;
    capture(1'b1, 1'b0);
    model_push();
    capture(1'b0, 1'b1);
    repeat (20) @(posedge clk);
    for (int i = 0; i < COL; i++) pa[i] = 900;
    capture(1'b1, 1'b0);
    run_burst(1'b0);
    check("F_n1_col0", got1[0], -556);
    repeat (200) @(posedge clk);

    // Reset mid-DIV aborts the burst
    for (int i = 0; i < COL; i++) begin pa[i] = i + 10; pb[i] = i; end
    capture(1'b1, 1'b1);
    repeat (50) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("G_reset_valid", int'(norm_valid), 0);
    check("G_reset_norm_1", psum_norm_1, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(posedge clk);
    model_push();
    capture(1'b1, 1'b1);
    run_burst(1'b1);
    check("H_n1_col0", got1[0], 2409);
    check("H_n1_col7", got1[7], 4096);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
